// File: rtl/usb_cmd_defs_pkg.sv
// usb_cmd_defs: command codes shared with the USB host software, queue entry
// layout, dispatcher FSM state encoding and small helper functions used by
// usb_cmd_dispatch and usb_cmd_queue.
package usb_cmd_defs;

  // Configuration commands (applied to local registers)
  localparam logic [7:0] CMD_SET_GAIN  = 8'h01;
  localparam logic [7:0] CMD_SET_PRF   = 8'h02;
  localparam logic [7:0] CMD_SET_DEPTH = 8'h03;
  // Action commands (forwarded over the req/ack handshake)
  localparam logic [7:0] CMD_START     = 8'h10;
  localparam logic [7:0] CMD_STOP      = 8'h11;
  localparam logic [7:0] CMD_SOFT_RST  = 8'h12;

  // One queue entry: 8-bit code + 32-bit parameter = 40 bits
  typedef struct packed {
    logic [7:0]  code;
    logic [31:0] param;
  } cmd_ent_t;

  localparam cmd_ent_t CMD_ENT_ZERO = '{code: 8'h00, param: 32'h0000_0000};

  // Dispatcher FSM, one-hot
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_DECODE = 4'b0010,
    ST_REQ    = 4'b0100,
    ST_REL    = 4'b1000
  } disp_state_t;

  // True for every code this block queues; anything else is counted as bad
  function automatic logic is_known_cmd(input logic [7:0] code);
    case (code)
      CMD_SET_GAIN, CMD_SET_PRF, CMD_SET_DEPTH,
      CMD_START, CMD_STOP, CMD_SOFT_RST: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Saturating 8-bit increment: counters stick at 8'hFF instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : (value + 8'd1);
  endfunction

endpackage

// File: rtl/usb_cmd_queue.sv
// usb_cmd_queue: register FIFO of {code,param} entries, single clock.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset (flushes the queue)
//   i_push, i_data   write side; a push while full is accepted only when a
//                    pop happens in the same cycle, otherwise it is ignored
//   i_pop, o_data    read side; o_data is the current head entry
//   o_full, o_empty  occupancy status
module usb_cmd_queue
  import usb_cmd_defs::*;
#(
  parameter int QAW = 2
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_push,
  input  cmd_ent_t i_data,
  input  logic     i_pop,
  output cmd_ent_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int             DEPTH    = 2 ** QAW;
  localparam logic [QAW:0]   CNT_FULL = (QAW + 1)'(DEPTH);
  localparam logic [QAW:0]   CNT_ZERO = (QAW + 1)'(0);
  localparam logic [QAW:0]   CNT_ONE  = (QAW + 1)'(1);
  localparam logic [QAW-1:0] PTR_ONE  = QAW'(1);

  cmd_ent_t       r_mem [DEPTH];
  logic [QAW-1:0] r_wr_ptr;
  logic [QAW-1:0] r_rd_ptr;
  logic [QAW:0]   r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == CNT_ZERO);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // When full, the slot freed by a same-cycle pop is reused (wr_ptr == rd_ptr)
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Entry storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= CMD_ENT_ZERO;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= CNT_ZERO;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/usb_cmd_dispatch.sv
// usb_cmd_dispatch: queues command strobes from the USB receiver, applies
// configuration writes to local registers and forwards action commands to the
// system-clock side over a 4-phase req/ack handshake.
// Ports:
//   i_clk_usb, i_rst_n            USB clock, asynchronous active-low reset
//   i_cmd_come/i_cmd/i_cmd_param  1-cycle command strobe with code and parameter
//   o_gain/o_prf_div/o_depth      configuration registers
//   o_cfg_upd                     1-cycle pulse when a config register changes
//   o_act_req/o_act_code/o_act_param  action request; code/param stable while req high
//   i_act_ack                     asynchronous acknowledge (synchronised here)
//   o_busy                        queue non-empty or a command in progress
//   o_bad_cnt/o_drop_cnt/o_timeout_cnt  saturating error counters
module usb_cmd_dispatch
  import usb_cmd_defs::*;
#(
  parameter int          QAW         = 2,
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [7:0]  GAIN_RST    = 8'h20,
  parameter logic [15:0] PRF_RST     = 16'd1000,
  parameter logic [13:0] DEPTH_RST   = 14'd4096
) (
  input  logic        i_clk_usb,
  input  logic        i_rst_n,
  input  logic        i_cmd_come,
  input  logic [7:0]  i_cmd,
  input  logic [31:0] i_cmd_param,
  output logic [7:0]  o_gain,
  output logic [15:0] o_prf_div,
  output logic [13:0] o_depth,
  output logic        o_cfg_upd,
  output logic        o_act_req,
  output logic [7:0]  o_act_code,
  output logic [31:0] o_act_param,
  input  logic        i_act_ack,
  output logic        o_busy,
  output logic [7:0]  o_bad_cnt,
  output logic [7:0]  o_drop_cnt,
  output logic [7:0]  o_timeout_cnt
);

  localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic        w_known;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_drop;
  cmd_ent_t    w_push_ent;
  cmd_ent_t    w_head;

  logic        r_ack_meta;
  logic        r_ack_s;
  disp_state_t r_state;
  logic [7:0]  r_hold_code;
  logic [31:0] r_hold_param;
  logic [TW-1:0] r_timer;

  logic [7:0]  r_gain;
  logic [15:0] r_prf_div;
  logic [13:0] r_depth;
  logic        r_cfg_upd;
  logic        r_act_req;
  logic [7:0]  r_act_code;
  logic [31:0] r_act_param;
  logic [7:0]  r_bad_cnt;
  logic [7:0]  r_drop_cnt;
  logic [7:0]  r_timeout_cnt;

  assign w_known    = is_known_cmd(i_cmd);
  assign w_push     = i_cmd_come && w_known;
  assign w_push_ent = '{code: i_cmd, param: i_cmd_param};
  // Pop only from IDLE; the head is latched into the hold registers
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_drop     = w_push && w_full && !w_pop;

  usb_cmd_queue #(
    .QAW (QAW)
  ) u_queue (
    .i_clk   (i_clk_usb),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_push_ent),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // 2-FF synchroniser for the acknowledge coming from the system clock domain
  always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= i_act_ack;
      r_ack_s    <= r_ack_meta;
    end
  end

  // Saturating counters for unknown codes and queue overflow
  always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bad_cnt  <= 8'h00;
      r_drop_cnt <= 8'h00;
    end else begin
      r_bad_cnt  <= (i_cmd_come && !w_known) ? sat_inc8(r_bad_cnt) : r_bad_cnt;
      r_drop_cnt <= w_drop ? sat_inc8(r_drop_cnt) : r_drop_cnt;
    end
  end

  // Dispatcher FSM with its registered outputs
  always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_hold_code   <= 8'h00;
      r_hold_param  <= 32'h0000_0000;
      r_timer       <= '0;
      r_gain        <= GAIN_RST;
      r_prf_div     <= PRF_RST;
      r_depth       <= DEPTH_RST;
      r_cfg_upd     <= 1'b0;
      r_act_req     <= 1'b0;
      r_act_code    <= 8'h00;
      r_act_param   <= 32'h0000_0000;
      r_timeout_cnt <= 8'h00;
    end else begin
      r_cfg_upd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_hold_code  <= w_head.code;
            r_hold_param <= w_head.param;
            r_state      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_state <= ST_IDLE;
          // Config writes pulse o_cfg_upd only when the value actually changes
          case (r_hold_code)
            CMD_SET_GAIN: begin
              if (r_hold_param[7:0] != r_gain) begin
                r_gain    <= r_hold_param[7:0];
                r_cfg_upd <= 1'b1;
              end
            end
            CMD_SET_PRF: begin
              if (r_hold_param[15:0] != r_prf_div) begin
                r_prf_div <= r_hold_param[15:0];
                r_cfg_upd <= 1'b1;
              end
            end
            CMD_SET_DEPTH: begin
              if (r_hold_param[13:0] != r_depth) begin
                r_depth   <= r_hold_param[13:0];
                r_cfg_upd <= 1'b1;
              end
            end
            CMD_START, CMD_STOP, CMD_SOFT_RST: begin
              r_act_req   <= 1'b1;
              r_act_code  <= r_hold_code;
              r_act_param <= r_hold_param;
              r_timer     <= '0;
              r_state     <= ST_REQ;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
        ST_REQ: begin
          // Ack wins over a timeout landing on the same cycle
          if (r_ack_s) begin
            r_act_req <= 1'b0;
            r_state   <= ST_REL;
          end else if (r_timer == TMO_LAST) begin
            r_act_req     <= 1'b0;
            r_timeout_cnt <= sat_inc8(r_timeout_cnt);
            r_state       <= ST_REL;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        ST_REL: begin
          // Code/param stay valid until the far side has released ack
          if (!r_ack_s) begin
            r_act_code  <= 8'h00;
            r_act_param <= 32'h0000_0000;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_act_req   <= 1'b0;
          r_act_code  <= 8'h00;
          r_act_param <= 32'h0000_0000;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gain        = r_gain;
  assign o_prf_div     = r_prf_div;
  assign o_depth       = r_depth;
  assign o_cfg_upd     = r_cfg_upd;
  assign o_act_req     = r_act_req;
  assign o_act_code    = r_act_code;
  assign o_act_param   = r_act_param;
  assign o_bad_cnt     = r_bad_cnt;
  assign o_drop_cnt    = r_drop_cnt;
  assign o_timeout_cnt = r_timeout_cnt;
  assign o_busy        = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_usb_cmd_dispatch.sv
// Self-checking bench for usb_cmd_dispatch: directed scenarios plus random
// traffic, all compared every cycle against a transaction-level model.
module tb_usb_cmd_dispatch;

  localparam int TB_TMO    = 32;
  localparam int TB_QDEPTH = 4;

  logic        clk;
  logic        i_rst_n;
  logic        i_cmd_come;
  logic [7:0]  i_cmd;
  logic [31:0] i_cmd_param;
  logic        i_act_ack;
  logic [7:0]  o_gain;
  logic [15:0] o_prf_div;
  logic [13:0] o_depth;
  logic        o_cfg_upd;
  logic        o_act_req;
  logic [7:0]  o_act_code;
  logic [31:0] o_act_param;
  logic        o_busy;
  logic [7:0]  o_bad_cnt;
  logic [7:0]  o_drop_cnt;
  logic [7:0]  o_timeout_cnt;

  usb_cmd_dispatch #(
    .QAW         (2),
    .TIMEOUT_CYC (TB_TMO)
  ) dut (
    .i_clk_usb     (clk),
    .i_rst_n       (i_rst_n),
    .i_cmd_come    (i_cmd_come),
    .i_cmd         (i_cmd),
    .i_cmd_param   (i_cmd_param),
    .o_gain        (o_gain),
    .o_prf_div     (o_prf_div),
    .o_depth       (o_depth),
    .o_cfg_upd     (o_cfg_upd),
    .o_act_req     (o_act_req),
    .o_act_code    (o_act_code),
    .o_act_param   (o_act_param),
    .i_act_ack     (i_act_ack),
    .o_busy        (o_busy),
    .o_bad_cnt     (o_bad_cnt),
    .o_drop_cnt    (o_drop_cnt),
    .o_timeout_cnt (o_timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  logic [7:0]  mq_code[$];
  logic [31:0] mq_param[$];
  logic [7:0]  m_gain;
  logic [15:0] m_prf;
  logic [13:0] m_depth;
  logic        m_upd;
  logic        m_req;
  logic [7:0]  m_code;
  logic [31:0] m_param;
  logic [7:0]  m_bad;
  logic [7:0]  m_drop;
  logic [7:0]  m_tmo;
  int          m_phase;     // 0 nothing in service, 1 command fetched, 2 requesting, 3 releasing
  logic [7:0]  m_cur_code;
  logic [31:0] m_cur_param;
  int          m_req_cycles;
  logic        m_ack_d1;    // ack seen at previous edge
  logic        m_ack_d2;    // ack seen two edges ago = synchronised ack

  // ---------------- ack responder (stimulus) ----------------
  bit resp_stuck;
  int resp_delay;
  int resp_cnt;

  int req_hi_cnt;
  int upd_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  task automatic model_reset();
    mq_code.delete();
    mq_param.delete();
    m_gain = 8'h20; m_prf = 16'd1000; m_depth = 14'd4096;
    m_upd = 1'b0; m_req = 1'b0; m_code = 8'h00; m_param = 32'h0;
    m_bad = 8'h00; m_drop = 8'h00; m_tmo = 8'h00;
    m_phase = 0; m_cur_code = 8'h00; m_cur_param = 32'h0; m_req_cycles = 0;
    m_ack_d1 = 1'b0; m_ack_d2 = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs now being driven
  task automatic step_model();
    logic ack_s;
    bit   popped;
    ack_s    = m_ack_d2;
    m_ack_d2 = m_ack_d1;
    m_ack_d1 = i_act_ack;
    m_upd    = 1'b0;
    popped   = 1'b0;
    case (m_phase)
      0: if (mq_code.size() > 0) begin
           m_cur_code  = mq_code.pop_front();
           m_cur_param = mq_param.pop_front();
           popped      = 1'b1;
         end
      1: begin
           if (m_cur_code == 8'h01 && m_cur_param[7:0] != m_gain) begin
             m_gain = m_cur_param[7:0]; m_upd = 1'b1;
           end else if (m_cur_code == 8'h02 && m_cur_param[15:0] != m_prf) begin
             m_prf = m_cur_param[15:0]; m_upd = 1'b1;
           end else if (m_cur_code == 8'h03 && m_cur_param[13:0] != m_depth) begin
             m_depth = m_cur_param[13:0]; m_upd = 1'b1;
           end else if (m_cur_code inside {8'h10, 8'h11, 8'h12}) begin
             m_req = 1'b1; m_code = m_cur_code; m_param = m_cur_param; m_req_cycles = 1;
           end
         end
      2: begin
           if (ack_s) m_req = 1'b0;
           else if (m_req_cycles == TB_TMO) begin
             m_req = 1'b0; m_tmo = sat8(m_tmo);
           end else m_req_cycles++;
         end
      3: if (!ack_s) begin m_code = 8'h00; m_param = 32'h0; end
      default: ;
    endcase
    // Phase bookkeeping expressed as "what happens next to the command in service"
    if (m_phase == 0)      m_phase = popped ? 1 : 0;
    else if (m_phase == 1) m_phase = m_req ? 2 : 0;
    else if (m_phase == 2) m_phase = m_req ? 2 : 3;
    else                   m_phase = (m_code == 8'h00 && m_param == 32'h0 && !ack_s) ? 0 : 3;
    if (i_cmd_come) begin
      if (i_cmd inside {8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12}) begin
        if (mq_code.size() < TB_QDEPTH) begin
          mq_code.push_back(i_cmd); mq_param.push_back(i_cmd_param);
        end else m_drop = sat8(m_drop);
      end else m_bad = sat8(m_bad);
    end
  endtask

  task automatic compare_all();
    chk("gain", {24'h0, o_gain}, {24'h0, m_gain});
    chk("prf_div", {16'h0, o_prf_div}, {16'h0, m_prf});
    chk("depth", {18'h0, o_depth}, {18'h0, m_depth});
    chk("cfg_upd", {31'h0, o_cfg_upd}, {31'h0, m_upd});
    chk("act_req", {31'h0, o_act_req}, {31'h0, m_req});
    chk("act_code", {24'h0, o_act_code}, {24'h0, m_code});
    chk("act_param", o_act_param, m_param);
    chk("busy", {31'h0, o_busy}, {31'h0, (mq_code.size() > 0 || m_phase != 0)});
    chk("bad_cnt", {24'h0, o_bad_cnt}, {24'h0, m_bad});
    chk("drop_cnt", {24'h0, o_drop_cnt}, {24'h0, m_drop});
    chk("timeout_cnt", {24'h0, o_timeout_cnt}, {24'h0, m_tmo});
    if (o_act_req) req_hi_cnt++;
    if (o_cfg_upd) upd_cnt++;
  endtask

  // 4-phase far side: ack follows req after resp_delay observed cycles
  task automatic respond();
    if (resp_stuck) begin
      i_act_ack = 1'b0; resp_cnt = 0;
    end else if (o_act_req != i_act_ack) begin
      resp_cnt++;
      if (resp_cnt >= resp_delay) begin i_act_ack = o_act_req; resp_cnt = 0; end
    end else resp_cnt = 0;
  endtask

  task automatic tick(input logic come, input logic [7:0] code, input logic [31:0] param);
    i_cmd_come = come; i_cmd = code; i_cmd_param = param;
    respond();
    step_model();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((m_phase != 0 || mq_code.size() != 0) && n < max_cyc) begin
      tick(1'b0, 8'h00, 32'h0);
      n++;
    end
    chk("idle_within_bound", {31'h0, (m_phase == 0 && mq_code.size() == 0)}, 32'h1);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_cmd_come = 1'b0; i_cmd = 8'h00; i_cmd_param = 32'h0; i_act_ack = 1'b0;
    resp_cnt = 0;
    #1;
    chk("rst_act_req", {31'h0, o_act_req}, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_gain", {24'h0, o_gain}, 32'h20);
    chk("rst_prf", {16'h0, o_prf_div}, 32'd1000);
    chk("rst_depth", {18'h0, o_depth}, 32'd4096);
    chk("rst_act_code", {24'h0, o_act_code}, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rc;
    logic [31:0] rp;
    i_rst_n = 1'b1; i_cmd_come = 1'b0; i_cmd = 8'h00; i_cmd_param = 32'h0; i_act_ack = 1'b0;
    resp_stuck = 1'b0; resp_delay = 5; resp_cnt = 0;
    model_reset();
    #2;
    do_reset();

    // 1: SET_GAIN 0x55 visible 3 cycles after the strobe, one pulse; repeat gives none
    upd_cnt = 0;
    tick(1'b1, 8'h01, 32'h0000_0055);
    tick(1'b0, 8'h00, 32'h0);
    chk("gain_not_yet", {24'h0, o_gain}, 32'h20);
    tick(1'b0, 8'h00, 32'h0);
    chk("gain_at_3", {24'h0, o_gain}, 32'h55);
    chk("upd_at_3", {31'h0, o_cfg_upd}, 32'h1);
    repeat (3) tick(1'b0, 8'h00, 32'h0);
    chk("upd_one_pulse", upd_cnt, 32'd1);
    upd_cnt = 0;
    tick(1'b1, 8'h01, 32'hFFFF_FF55);
    repeat (5) tick(1'b0, 8'h00, 32'h0);
    chk("upd_same_value", upd_cnt, 32'd0);

    // 2: START param 7, ack after 5 cycles
    req_hi_cnt = 0;
    tick(1'b1, 8'h10, 32'd7);
    tick(1'b0, 8'h00, 32'h0);
    tick(1'b0, 8'h00, 32'h0);
    chk("start_req", {31'h0, o_act_req}, 32'h1);
    chk("start_code", {24'h0, o_act_code}, 32'h10);
    chk("start_param", o_act_param, 32'd7);
    wait_idle(100);
    chk("start_req_len", req_hi_cnt, 32'd7);
    chk("start_code_clr", {24'h0, o_act_code}, 32'h0);

    // 3: unknown code
    tick(1'b1, 8'h7F, 32'h1234_5678);
    chk("bad_busy", {31'h0, o_busy}, 32'h0);
    repeat (2) tick(1'b0, 8'h00, 32'h0);
    chk("bad_cnt_1", {24'h0, o_bad_cnt}, 32'h1);
    chk("bad_gain_kept", {24'h0, o_gain}, 32'h55);

    // 4: ack never comes -> timeout, then next command still served
    resp_stuck = 1'b1;
    req_hi_cnt = 0;
    tick(1'b1, 8'h10, 32'd9);
    wait_idle(TB_TMO + 20);
    chk("tmo_req_len", req_hi_cnt, TB_TMO);
    chk("tmo_cnt_1", {24'h0, o_timeout_cnt}, 32'h1);
    tick(1'b1, 8'h01, 32'h0000_00A5);
    wait_idle(20);
    chk("after_tmo_gain", {24'h0, o_gain}, 32'hA5);

    // 5: stalled handshake + 6 back-to-back SET_GAIN -> 4 queued, 2 dropped
    tick(1'b1, 8'h11, 32'd1);
    for (int i = 0; i < 6; i++) tick(1'b1, 8'h01, 32'h11 + i);
    chk("drop_cnt_2", {24'h0, o_drop_cnt}, 32'h2);
    wait_idle(TB_TMO + 40);
    chk("order_last_gain", {24'h0, o_gain}, 32'h14);
    for (int i = 0; i < 300; i++) tick(1'b1, 8'hC0 + 8'(i % 16), 32'h0);
    chk("bad_cnt_sat", {24'h0, o_bad_cnt}, 32'hFF);
    resp_stuck = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        resp_stuck = ($urandom_range(0, 4) == 0);
        resp_delay = $urandom_range(1, 8);
      end
      case ($urandom_range(0, 9))
        0:       rc = 8'h01;
        1:       rc = 8'h02;
        2:       rc = 8'h03;
        3:       rc = 8'h10;
        4:       rc = 8'h11;
        5:       rc = 8'h12;
        default: rc = 8'($urandom);
      endcase
      rp = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      tick($urandom_range(0, 2) == 0, rc, rp);
    end
    resp_stuck = 1'b0; resp_delay = 3;
    wait_idle(2000);

    // 6: reset in the middle of a request
    resp_delay = 20;
    tick(1'b1, 8'h01, 32'h0000_0099);
    tick(1'b1, 8'h10, 32'hDEAD_BEEF);
    for (int i = 0; i < 20 && !o_act_req; i++) tick(1'b0, 8'h00, 32'h0);
    chk("pre_rst_req", {31'h0, o_act_req}, 32'h1);
    tick(1'b1, 8'h02, 32'h0000_0033);
    chk("pre_rst_gain", {24'h0, o_gain}, 32'h99);
    chk("pre_rst_busy", {31'h0, o_busy}, 32'h1);
    do_reset();
    resp_delay = 5;
    tick(1'b1, 8'h02, 32'h1234_ABCD);
    wait_idle(20);
    chk("post_rst_prf", {16'h0, o_prf_div}, 32'hABCD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
